// File: rtl/ifetch_ctrl_pkg.sv
// Shared fetch types: the NOP encoding lives in common, fetch payload and FSM state in pipes.
package common;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

package pipes;
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } ifetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fetch_data_t;
endpackage

// File: rtl/ifetch_hbuf.sv
// One-entry hold buffer parking a fetched word while decode is stalled on an earlier one.
module ifetch_hbuf
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  fetch_data_t i_data,
    output fetch_data_t o_data
);

    fetch_data_t r_buf;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_buf <= '0;
        end else if (i_load) begin
            r_buf       <= i_data;
            r_buf.valid <= 1'b1;
        end else if (i_unload) begin
            r_buf.valid <= 1'b0;
        end
    end

    assign o_data = r_buf;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request, IF/ID output registers, hold buffer.
// Define IFETCH_MISALIGN_EXC_EN to turn a misaligned pc into a NOP with out_exc set instead of a bus request.
module ifetch_ctrl
    import common::*;
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    input  logic        flush,
    input  logic        id_stall,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        pc_stall,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc
);

    ifetch_state_t r_state;
    ifetch_state_t w_state_nxt;
    fetch_data_t   r_out;
    fetch_data_t   w_cmpl_data;
    fetch_data_t   w_hbuf_data;

    logic w_misalign;
    logic w_req;
    logic w_resp;
    logic w_cmpl;
    logic w_blocked;
    logic w_cmpl_out;
    logic w_hb_load;
    logic w_unload;

`ifdef IFETCH_MISALIGN_EXC_EN
    assign w_misalign = (r_state == REQ) && (pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req      = !reset && (r_state == REQ) && !w_misalign;
    assign w_resp     = (w_req && iresp_addr_ok && iresp_data_ok)
                      || ((r_state == WAIT) && iresp_data_ok);
    // A flush swallows any word arriving in the same cycle.
    assign w_cmpl     = !flush && (w_resp || w_misalign);
    assign w_blocked  = r_out.valid && id_stall;
    assign w_cmpl_out = w_cmpl && !w_blocked;
    assign w_hb_load  = w_cmpl && w_blocked;
    assign w_unload   = !flush && (r_state == HOLD) && !id_stall && w_hbuf_data.valid;

    assign w_cmpl_data.valid = 1'b1;
    assign w_cmpl_data.pc    = pc;
    assign w_cmpl_data.instr = w_misalign ? NOP_INSTR : iresp_data;
    assign w_cmpl_data.exc   = w_misalign;

    assign ireq_valid = w_req;
    assign ireq_addr  = pc;
    assign pc_stall   = reset || !(flush || w_cmpl_out || w_unload);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            REQ: begin
                if (flush)
                    w_state_nxt = (w_req && iresp_addr_ok && !iresp_data_ok) ? DROP : REQ;
                else if (w_cmpl)
                    w_state_nxt = w_blocked ? HOLD : REQ;
                else if (w_req && iresp_addr_ok)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                if (flush)
                    w_state_nxt = iresp_data_ok ? REQ : DROP;
                else if (w_cmpl)
                    w_state_nxt = w_blocked ? HOLD : REQ;
            end
            HOLD: begin
                if (flush || !id_stall)
                    w_state_nxt = REQ;
            end
            DROP: begin
                if (iresp_data_ok)
                    w_state_nxt = REQ;
            end
            default: w_state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= REQ;
        else
            r_state <= w_state_nxt;
    end

    // IF/ID boundary registers; contents are kept while decode stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (flush) begin
            r_out.valid <= 1'b0;
        end else if (w_cmpl_out) begin
            r_out <= w_cmpl_data;
        end else if (w_unload) begin
            r_out <= w_hbuf_data;
        end else if (!id_stall) begin
            r_out.valid <= 1'b0;
        end
    end

    ifetch_hbuf u_hbuf (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_hb_load),
        .i_unload (w_unload),
        .i_clear  (flush),
        .i_data   (w_cmpl_data),
        .o_data   (w_hbuf_data)
    );

    assign out_valid = r_out.valid;
    assign out_pc    = r_out.pc;
    assign out_instr = r_out.instr;
    assign out_exc   = r_out.exc;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus a randomized bus/decoder run against a transaction-level model.
`timescale 1ns/1ps
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic        flush;
    logic        id_stall;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
    logic        pc_stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .flush         (flush),
        .id_stall      (id_stall),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (addr_ok),
        .iresp_data_ok (data_ok),
        .iresp_data    (data),
        .pc_stall      (pc_stall),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_exc       (out_exc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; id_stall = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; data = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; id_stall = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; data = '0; pc = 64'h1234_5678;
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr, out_exc} !== 98'd0) begin
            n_fail++;
            $display("FAIL reset_out: got %b/%h/%h/%b want 0/0/0/0", out_valid, out_pc, out_instr, out_exc);
        end
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ireq_valid=%b pc_stall=%b want 0/1", ireq_valid, pc_stall);
        end
        reset = 1'b0; pc = 64'h8000_1000;
        #1;
        n_checks++;
        if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_1000}) begin
            n_fail++;
            $display("FAIL reset_release_req: got %b/%h want 1/80001000", ireq_valid, ireq_addr);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hbuf_empty: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_basic();
        do_reset();
        pc = 64'h8000_0000; addr_ok = 1'b1; data_ok = 1'b1; data = 32'h0000_0513;
        #1;
        n_checks++;
        if ({ireq_valid, ireq_addr, pc_stall} !== {1'b1, 64'h8000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_req: got %b/%h/%b want 1/80000000/0", ireq_valid, ireq_addr, pc_stall);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr, out_exc} !== {1'b1, 64'h8000_0000, 32'h0000_0513, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_out: got %b/%h/%h/%b want 1/80000000/00000513/0", out_valid, out_pc, out_instr, out_exc);
        end
        pc = 64'h8000_0004; addr_ok = 1'b0; data_ok = 1'b0;
        #1;
        n_checks++;
        if (pc_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_idle_stall: pc_stall=%b want 1", pc_stall);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_clear: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_wait();
        do_reset();
        pc = 64'h8000_0100; addr_ok = 1'b1; data_ok = 1'b0;
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL wait_c1: got ireq_valid=%b pc_stall=%b want 1/1", ireq_valid, pc_stall);
        end
        tick();
        for (int c = 2; c <= 3; c++) begin
            addr_ok = 1'b0; data_ok = 1'b0;
            #1;
            n_checks++;
            if ({ireq_valid, pc_stall, out_valid} !== 3'b010) begin
                n_fail++;
                $display("FAIL wait_c%0d: got %b%b%b want 010", c, ireq_valid, pc_stall, out_valid);
            end
            tick();
        end
        data_ok = 1'b1; data = 32'h00A0_0093;
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL wait_c4: got ireq_valid=%b pc_stall=%b want 0/0", ireq_valid, pc_stall);
        end
        tick();
        data_ok = 1'b0;
        n_checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h8000_0100, 32'h00A0_0093}) begin
            n_fail++;
            $display("FAIL wait_out: got %b/%h/%h want 1/80000100/00a00093", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_hold();
        do_reset();
        pc = 64'h8000_0200; addr_ok = 1'b1; data_ok = 1'b1; data = 32'h0010_0113;
        tick();
        pc = 64'h8000_0204; id_stall = 1'b1; data = 32'h1111_1113;
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_cmpl: got ireq_valid=%b pc_stall=%b want 1/1", ireq_valid, pc_stall);
        end
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        n_checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h8000_0200, 32'h0010_0113}) begin
            n_fail++;
            $display("FAIL hold_out_kept: got %b/%h/%h want 1/80000200/00100113", out_valid, out_pc, out_instr);
        end
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_idle: got ireq_valid=%b pc_stall=%b want 0/1", ireq_valid, pc_stall);
        end
        tick();
        id_stall = 1'b0;
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_unload: got ireq_valid=%b pc_stall=%b want 0/0", ireq_valid, pc_stall);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h8000_0204, 32'h1111_1113}) begin
            n_fail++;
            $display("FAIL hold_out_new: got %b/%h/%h want 1/80000204/11111113", out_valid, out_pc, out_instr);
        end
        pc = 64'h8000_0208;
        #1;
        n_checks++;
        if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0208}) begin
            n_fail++;
            $display("FAIL hold_resume: got %b/%h want 1/80000208", ireq_valid, ireq_addr);
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        pc = 64'h8000_0300; addr_ok = 1'b1; data_ok = 1'b0;
        tick();
        addr_ok = 1'b0; flush = 1'b1;
        #1;
        n_checks++;
        if (pc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flushw_stall: pc_stall=%b want 0", pc_stall);
        end
        tick();
        flush = 1'b0; pc = 64'h8000_4000;
        #1;
        n_checks++;
        if ({ireq_valid, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL flushw_drop: got ireq_valid=%b out_valid=%b want 0/0", ireq_valid, out_valid);
        end
        tick();
        data_ok = 1'b1; data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL flushw_stale: got ireq_valid=%b pc_stall=%b want 0/1", ireq_valid, pc_stall);
        end
        tick();
        data_ok = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_instr === 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL flushw_discard: got %b/%h want 0 and not deadbeef", out_valid, out_instr);
        end
        #1;
        n_checks++;
        if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_4000}) begin
            n_fail++;
            $display("FAIL flushw_retarget: got %b/%h want 1/80004000", ireq_valid, ireq_addr);
        end
        addr_ok = 1'b1; data_ok = 1'b1; data = 32'h0040_0213;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        n_checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h8000_4000, 32'h0040_0213}) begin
            n_fail++;
            $display("FAIL flushw_refetch: got %b/%h/%h want 1/80004000/00400213", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_flush_data();
        do_reset();
        pc = 64'h8000_0400; addr_ok = 1'b1; data_ok = 1'b1; data = 32'h0050_0293;
        tick();
        pc = 64'h8000_0404; flush = 1'b1; data = 32'hCAFE_0013;
        #1;
        n_checks++;
        if (pc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flushd_stall: pc_stall=%b want 0", pc_stall);
        end
        tick();
        flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; pc = 64'h8000_8000;
        n_checks++;
        if (out_valid !== 1'b0 || out_instr === 32'hCAFE_0013) begin
            n_fail++;
            $display("FAIL flushd_discard: got %b/%h want 0 and not cafe0013", out_valid, out_instr);
        end
        #1;
        n_checks++;
        if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_8000}) begin
            n_fail++;
            $display("FAIL flushd_req: got %b/%h want 1/80008000", ireq_valid, ireq_addr);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        pc = 64'h8000_0002; addr_ok = 1'b0; data_ok = 1'b0; data = 32'h0000_0533;
`ifdef IFETCH_MISALIGN_EXC_EN
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL misalign_req: got ireq_valid=%b pc_stall=%b want 0/0", ireq_valid, pc_stall);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr, out_exc} !== {1'b1, 64'h8000_0002, 32'h0000_0013, 1'b1}) begin
            n_fail++;
            $display("FAIL misalign_out: got %b/%h/%h/%b want 1/80000002/00000013/1", out_valid, out_pc, out_instr, out_exc);
        end
`else
        addr_ok = 1'b1; data_ok = 1'b1;
        #1;
        n_checks++;
        if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0002}) begin
            n_fail++;
            $display("FAIL misalign_req: got %b/%h want 1/80000002", ireq_valid, ireq_addr);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr, out_exc} !== {1'b1, 64'h8000_0002, 32'h0000_0533, 1'b0}) begin
            n_fail++;
            $display("FAIL misalign_out: got %b/%h/%h/%b want 1/80000002/00000533/0", out_valid, out_pc, out_instr, out_exc);
        end
`endif
        addr_ok = 1'b0; data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pc = 64'h8000_0500; addr_ok = 1'b1; data_ok = 1'b0;
        tick();
        reset = 1'b1; addr_ok = 1'b0;
        #1;
        n_checks++;
        if ({ireq_valid, pc_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got ireq_valid=%b pc_stall=%b want 0/1", ireq_valid, pc_stall);
        end
        tick();
        reset = 1'b0; pc = 64'h8000_0600;
        #1;
        n_checks++;
        if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0600}) begin
            n_fail++;
            $display("FAIL rstmid_req: got %b/%h want 1/80000600", ireq_valid, ireq_addr);
        end
        addr_ok = 1'b1; data_ok = 1'b1; data = 32'h0060_0313;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        n_checks++;
        if ({out_valid, out_instr} !== {1'b1, 32'h0060_0313}) begin
            n_fail++;
            $display("FAIL rstmid_out: got %b/%h want 1/00600313", out_valid, out_instr);
        end
    endtask

    // Transaction-level reference: tracks the bus transaction, whether its word is stale,
    // a parked word and the IF/ID contents, then predicts outputs from the fetch rules.
    task automatic test_random();
        bit          m_pending = 0, m_stale = 0, m_held = 0;
        int          due = 0;
        logic [63:0] h_pc = '0, o_pc = '0, cur_pc;
        logic [31:0] h_instr = '0, o_instr = '0, n_instr;
        bit          h_exc = 0, o_valid = 0, o_exc = 0;
        bit          mis, exp_req, exp_stall, word, cmpl, mis_cmpl;

        do_reset();
        cur_pc = 64'h8000_0000;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            n_checks++;
            if (out_valid !== o_valid || (o_valid && {out_pc, out_instr, out_exc} !== {o_pc, o_instr, o_exc})) begin
                n_fail++;
                $display("FAIL rand_out c%0d: got %b/%h/%h/%b want %b/%h/%h/%b", cyc,
                         out_valid, out_pc, out_instr, out_exc, o_valid, o_pc, o_instr, o_exc);
            end
            flush    = ($urandom_range(0, 11) == 0);
            id_stall = ($urandom_range(0, 9) < 4);
            data     = $urandom;
            pc       = cur_pc;
`ifdef IFETCH_MISALIGN_EXC_EN
            mis = (cur_pc[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            exp_req  = !m_pending && !m_held && !mis;
            mis_cmpl = !m_pending && !m_held && mis;
            #1;
            n_checks++;
            if (ireq_valid !== exp_req || (exp_req && ireq_addr !== cur_pc)) begin
                n_fail++;
                $display("FAIL rand_req c%0d: got %b/%h want %b/%h", cyc, ireq_valid, ireq_addr, exp_req, cur_pc);
            end
            addr_ok = 1'b0; data_ok = 1'b0;
            if (m_pending) begin
                data_ok = (cyc == due);
            end else if (exp_req && $urandom_range(0, 9) < 7) begin
                addr_ok = 1'b1;
                data_ok = $urandom_range(0, 1);
                if (!data_ok) begin
                    m_pending = 1;
                    due = cyc + $urandom_range(1, 3);
                end
            end
            word = data_ok;
            if (word) m_pending = 0;
            exp_stall = 1;
            if (flush) begin
                exp_stall = 0;
                o_valid   = 0;
                m_held    = 0;
                m_stale   = !word && m_pending;
            end else if (word && m_stale) begin
                m_stale = 0;
            end else begin
                cmpl = word || mis_cmpl;
                n_instr = mis_cmpl ? 32'h0000_0013 : data;
                if (cmpl && o_valid && id_stall) begin
                    m_held = 1; h_pc = cur_pc; h_instr = n_instr; h_exc = mis_cmpl;
                end else if (cmpl) begin
                    o_valid = 1; o_pc = cur_pc; o_instr = n_instr; o_exc = mis_cmpl;
                    exp_stall = 0;
                end else if (m_held && !id_stall) begin
                    o_valid = 1; o_pc = h_pc; o_instr = h_instr; o_exc = h_exc;
                    m_held = 0;
                    exp_stall = 0;
                end else if (!id_stall) begin
                    o_valid = 0;
                end
            end
            @(negedge clk);
            n_checks++;
            if (pc_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL rand_stall c%0d: got %b want %b", cyc, pc_stall, exp_stall);
            end
            if (!exp_stall) begin
                if (flush) cur_pc = {32'h8000_0000 | 32'($urandom_range(0, 65535)), 32'h0} >> 32 << 2;
                else       cur_pc = cur_pc + 64'd4;
                if ($urandom_range(0, 7) == 0) cur_pc = {cur_pc[63:2], 2'b10};
                else                           cur_pc = {cur_pc[63:2], 2'b00};
            end
            tick();
        end
        flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; id_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_hold();
        test_flush_wait();
        test_flush_data();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
